robot_controller: RTL and testbench
===================================

// Module: robot_controller
// PURPOSE
//   Synthesizable pipe-cleaning robot brain: consumes the four environment sensors and issues one
//   action per clock (front / turn-left / remove). Left-hand wall follower with trash removal.
//   Sits opposite the map/sensor model: the model drives sensors after the negedge and samples
//   actions on the posedge.
// PARAMETERS
//   REMOVE_CYCLES  3  consecutive remove cycles needed to clear one trash cell
//   STALL_TURNS    4  max consecutive turn cycles before a stall halt (ROBOT_STALL_DETECT_EN only)
// PORTS
//   clock    in   1  rising-edge clock
//   reset    in   1  asynchronous, active-low; clears all state
//   head     in   1  wall or map edge directly ahead
//   left     in   1  wall or map edge on the robot's left
//   under    in   1  exit marker under the robot
//   barrier  in   1  trash cell directly ahead (head=0 while barrier=1)
//   front    out  1  move one cell forward this cycle
//   turn     out  1  rotate 90 deg left this cycle (N->W->S->E->N)
//   remove   out  1  remove-trash strobe for the cell ahead
//   halted   out  1  robot in HALT; all actions 0
// BEHAVIOUR
// - Actions are Mealy: a combinational function of registered state and current sensors.
//   State updates on the posedge. At most one of front/turn/remove is 1 in any cycle.
// - While reset=0: state=SEEK, rem_cnt=0, stall_cnt=0, ret_state=SEEK.
//   front=turn=remove=halted=0 regardless of sensors.
// - Global priority, every non-HALT state:
//   under=1 -> all actions 0, next state HALT.
//   else barrier=1 -> remove=1, rem_cnt=1, ret_state=current state, next state REMOVE.
// - SEEK (find a wall):
//   left=1 -> apply the FOLLOW rule this cycle, next state FOLLOW.
//   left=0, head=0 -> front.
//   left=0, head=1 -> turn; stay in SEEK.
// - FOLLOW:
//   left=0 -> turn, next state TURNED.
//   left=1, head=0 -> front.
//   left=1, head=1 -> turn; stay in FOLLOW.
// - TURNED (just turned into a gap):
//   head=0 -> front, next state FOLLOW.
//   head=1 -> turn, next state FOLLOW.
// - REMOVE:
//   barrier=1 -> remove=1, rem_cnt+1. The cycle that asserts remove for the REMOVE_CYCLES-th
//   time has next state ret_state, rem_cnt=0. The model clears the cell on that sample.
//   barrier=0 early (abort) -> all actions 0, rem_cnt=0, next state ret_state.
//   under=1 has priority here as well.
// - HALT: all actions 0, halted=1. Exits only through reset.
// - rem_cnt width is $clog2(REMOVE_CYCLES+1). It never wraps.
//   A reset mid-removal restarts the count; the partial removal is lost.
// CONFIGURATION
// - ROBOT_STALL_DETECT_EN defined:
//   stall_cnt counts consecutive cycles with turn=1. It clears on front=1 and holds on remove
//   or idle cycles. A cycle that would assert turn while stall_cnt==STALL_TURNS outputs all
//   zeros instead, and the next state is HALT.
// - ROBOT_STALL_DETECT_EN undefined: no stall_cnt. Turning is unbounded.
// TESTING
// 1 reset=0 with head=0 left=0 -> front=turn=remove=halted=0.
//   Release reset, head=0 left=0 -> front=1 (SEEK).
// 2 SEEK, head=1 left=0 for 3 cycles, then left=1 head=0 ->
//   turn=1 x3, then front=1; state FOLLOW.
// 3 FOLLOW, barrier=1 held 3 cycles, then 0 -> remove=1 on exactly 3 samples, front=0 and
//   turn=0 throughout; 4th cycle with left=1 head=0 -> front=1.
// 4 REMOVE, barrier drops after 1 cycle -> remove=1 once, then all 0 for 1 cycle.
//   Return to FOLLOW; a later barrier again needs 3 full cycles.
// 5 under=1 during FOLLOW and again during REMOVE -> outputs 0 that cycle, halted=1 next cycle.
//   Stays halted for 10 cycles under any sensors; reset clears it.
// 6 ROBOT_STALL_DETECT_EN, FOLLOW, head=1 left=1 for 6 cycles -> turn=1 x4, then all 0 and
//   halted=1. Without the macro -> turn=1 all 6 cycles.

Source files
------------

// File: rtl/robot_controller.sv
// Left-hand wall-following pipe robot with trash removal; Mealy actions.
// Optional stall halt when ROBOT_STALL_DETECT_EN is defined.
module robot_controller #(
   parameter int REMOVE_CYCLES = 3
`ifdef ROBOT_STALL_DETECT_EN
   , parameter int STALL_TURNS = 4
`endif
) (
   input  logic clock,
   input  logic reset,
   input  logic head,
   input  logic left,
   input  logic under,
   input  logic barrier,
   output logic front,
   output logic turn,
   output logic remove,
   output logic halted
);

   localparam logic [2:0] S_SEEK   = 3'd0;
   localparam logic [2:0] S_FOLLOW = 3'd1;
   localparam logic [2:0] S_TURNED = 3'd2;
   localparam logic [2:0] S_REMOVE = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   localparam int RW = $clog2(REMOVE_CYCLES + 1);
   localparam logic [RW-1:0] RC_LAST = RW'(REMOVE_CYCLES - 1);
   localparam logic [RW-1:0] RC_ONE  = RW'(1);

   logic [2:0]    r_state;
   logic [2:0]    r_ret;
   logic [RW-1:0] r_rem_cnt;
   logic [2:0]    w_nxt_state;
   logic [2:0]    w_nxt_ret;
   logic [RW-1:0] w_nxt_rem;
   logic          w_front;
   logic          w_turn;
   logic          w_remove;

`ifdef ROBOT_STALL_DETECT_EN
   localparam int SW = $clog2(STALL_TURNS + 1);
   localparam logic [SW-1:0] ST_MAX = SW'(STALL_TURNS);
   logic [SW-1:0] r_stall_cnt;
   logic [SW-1:0] w_nxt_stall;
`endif

   // Action selection and next-state logic for all states
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ret   = r_ret;
      w_nxt_rem   = r_rem_cnt;
      w_front     = 1'b0;
      w_turn      = 1'b0;
      w_remove    = 1'b0;
`ifdef ROBOT_STALL_DETECT_EN
      w_nxt_stall = r_stall_cnt;
`endif
      if (r_state == S_HALT) begin
         w_nxt_state = S_HALT;
      end else if (under) begin
         w_nxt_state = S_HALT;
      end else if (r_state == S_REMOVE) begin
         // abort or final hit both return to the interrupted state
         w_nxt_state = r_ret;
         w_nxt_rem   = '0;
         if (barrier) begin
            w_remove = 1'b1;
            if (r_rem_cnt != RC_LAST) begin
               w_nxt_state = S_REMOVE;
               w_nxt_rem   = r_rem_cnt + 1'b1;
            end
         end
      end else if (barrier) begin
         w_remove = 1'b1;
         if (REMOVE_CYCLES > 1) begin
            w_nxt_ret   = r_state;
            w_nxt_state = S_REMOVE;
            w_nxt_rem   = RC_ONE;
         end
      end else begin
         case (r_state)
            S_SEEK: begin
               w_front = !head;
               w_turn  = head;
               if (left) w_nxt_state = S_FOLLOW;
            end
            S_FOLLOW: begin
               if (!left) begin
                  w_turn      = 1'b1;
                  w_nxt_state = S_TURNED;
               end else begin
                  w_front = !head;
                  w_turn  = head;
               end
            end
            S_TURNED: begin
               w_front     = !head;
               w_turn      = head;
               w_nxt_state = S_FOLLOW;
            end
            default: w_nxt_state = S_HALT;
         endcase
      end
`ifdef ROBOT_STALL_DETECT_EN
      // too many turns in a row: suppress the turn and give up
      if (w_turn && r_stall_cnt == ST_MAX) begin
         w_turn      = 1'b0;
         w_nxt_state = S_HALT;
      end else if (w_turn) begin
         w_nxt_stall = r_stall_cnt + 1'b1;
      end else if (w_front) begin
         w_nxt_stall = '0;
      end
`endif
   end

   // State registers, cleared asynchronously by reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= S_SEEK;
         r_ret     <= S_SEEK;
         r_rem_cnt <= '0;
      end else begin
         r_state   <= w_nxt_state;
         r_ret     <= w_nxt_ret;
         r_rem_cnt <= w_nxt_rem;
      end
   end

`ifdef ROBOT_STALL_DETECT_EN
   // Consecutive-turn counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_stall_cnt <= '0;
      else        r_stall_cnt <= w_nxt_stall;
   end
`endif

   assign front  = reset & w_front;
   assign turn   = reset & w_turn;
   assign remove = reset & w_remove;
   assign halted = reset & (r_state == S_HALT);

endmodule

// File: tb/tb_robot_controller.sv
// Randomized + directed bench for robot_controller with an in-bench
// behavioural model of the wall follower.
module tb_robot_controller;

   localparam int RC = 3;
   localparam int ST = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic head = 1'b0;
   logic left = 1'b0;
   logic under = 1'b0;
   logic barrier = 1'b0;
   logic front, turn, remove, halted;

   always #5 clock = ~clock;

   robot_controller #(.REMOVE_CYCLES(RC)) dut (
      .clock(clock), .reset(reset), .head(head), .left(left),
      .under(under), .barrier(barrier), .front(front), .turn(turn),
      .remove(remove), .halted(halted)
   );

   typedef enum int {SEEK, FOLLOW, TURNED, REMOVING, HALTED} mode_e;

   mode_e mode = SEEK;
   mode_e ret  = SEEK;
   int hits  = 0;
   int turns = 0;
   int tests = 0;
   int fails = 0;
   logic [3:0] act;

   // expected {front,turn,remove,halted} for this cycle; advances model
   task automatic model(input logic r, h, l, u, b, output logic [3:0] e);
      logic f, t, rm;
      mode_e nm;
      f = 1'b0; t = 1'b0; rm = 1'b0; nm = mode;
      if (!r) begin
         e = 4'b0000; mode = SEEK; ret = SEEK; hits = 0; turns = 0;
      end else if (mode == HALTED) begin
         e = 4'b0001;
      end else begin
         if (u) nm = HALTED;
         else if (mode == REMOVING) begin
            if (b) begin
               rm = 1'b1; hits++;
               if (hits == RC) begin nm = ret; hits = 0; end
            end else begin
               hits = 0; nm = ret;
            end
         end else if (b) begin
            rm = 1'b1; hits = 1; ret = mode; nm = REMOVING;
            if (hits == RC) begin nm = mode; hits = 0; end
         end else begin
            case (mode)
               SEEK:   begin t = h; f = !h; if (l) nm = FOLLOW; end
               FOLLOW: if (!l) begin t = 1'b1; nm = TURNED; end
                       else begin t = h; f = !h; end
               TURNED: begin t = h; f = !h; nm = FOLLOW; end
               default: ;
            endcase
         end
`ifdef ROBOT_STALL_DETECT_EN
         if (t && turns == ST) begin t = 1'b0; nm = HALTED; end
         else if (t) turns++;
         else if (f) turns = 0;
`endif
         mode = nm;
         e = {f, t, rm, 1'b0};
      end
   endtask

   task automatic cyc(input logic r, h, l, u, b);
      logic [3:0] e;
      @(negedge clock);
      #1;
      reset = r; head = h; left = l; under = u; barrier = b;
      #2;
      act = {front, turn, remove, halted};
      model(r, h, l, u, b, e);
      tests++;
      if (act !== e) begin
         fails++;
         $display("FAIL model t=%0t actual=%b required=%b", $time, act, e);
      end
      tests++;
      if ($countones(act[3:1]) > 1) begin
         fails++;
         $display("FAIL onehot t=%0t actual=%b", $time, act);
      end
   endtask

   task automatic lit(input string nm, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   initial begin
      // reset and first move
      cyc(0, 0, 0, 0, 0); lit("reset", 4'b0000);
      cyc(1, 0, 0, 0, 0); lit("seek_front", 4'b1000);
      // find a wall
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 0, 0); lit("seek_turn", 4'b0100);
      end
      cyc(1, 0, 1, 0, 0); lit("seek_to_follow", 4'b1000);
      // full removal
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 1, 0, 1); lit("remove_full", 4'b0010);
      end
      cyc(1, 0, 1, 0, 0); lit("after_remove", 4'b1000);
      // aborted removal, then a fresh full one
      cyc(1, 0, 1, 0, 1); lit("abort_hit", 4'b0010);
      cyc(1, 0, 1, 0, 0); lit("abort_idle", 4'b0000);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 1, 0, 1); lit("remove_again", 4'b0010);
      end
      cyc(1, 0, 1, 0, 0); lit("after_remove2", 4'b1000);
      // boxed in: turn repeatedly
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 1, 0, 0);
`ifdef ROBOT_STALL_DETECT_EN
         if (i < 4) lit("stall_turn", 4'b0100);
         else if (i == 4) lit("stall_stop", 4'b0000);
         else lit("stall_halt", 4'b0001);
`else
         lit("spin_turn", 4'b0100);
`endif
      end
      // exit marker in FOLLOW
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0); lit("to_follow", 4'b1000);
      cyc(1, 0, 1, 1, 0); lit("under_follow", 4'b0000);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         lit("halt_hold", 4'b0001);
      end
      cyc(0, 1, 1, 1, 0); lit("halt_reset", 4'b0000);
      // exit marker during REMOVE
      cyc(1, 0, 1, 0, 0); lit("to_follow2", 4'b1000);
      cyc(1, 0, 1, 0, 1); lit("rm_start", 4'b0010);
      cyc(1, 0, 1, 1, 1); lit("under_remove", 4'b0000);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, 1'($urandom), 1'($urandom), 1'($urandom));
         lit("halt_hold2", 4'b0001);
      end
      cyc(0, 0, 0, 0, 0);
      // random walk
      for (int i = 0; i < 3000; i++) begin
         logic r, h, l, u, b;
         r = ($urandom_range(39) != 0);
         l = 1'($urandom);
         h = 1'($urandom);
         b = ($urandom_range(4) == 0);
         u = ($urandom_range(59) == 0);
         if (b) h = 1'b0;
         cyc(r, h, l, u, b);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
